// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: merges load returns and ALU results into one RF write per cycle
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int QDEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exe_valid,
  input  logic                 exe_needs_wb,
  input  logic [ADDR_W-1:0]    exe_rd,
  input  logic [DATA_W-1:0]    exe_data,
  output logic                 exe_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_wen,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic                 err
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] q_rd   [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;

  logic push_req, push_ok, pop, enq, has_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign exe_ready = (count < CW'(QDEPTH));
  assign has_q     = (count != '0);
  assign push_req  = exe_valid & exe_needs_wb;
  assign push_ok   = push_req & exe_ready;
  assign pop       = !mem_valid && has_q;
  // A push bypasses the queue only when nothing else competes for the write port.
  assign enq       = push_ok && (mem_valid || has_q);

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i]) pend_mask[q_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
    end else begin
      if (pop) begin
        head        <= wrap_inc(head);
        q_vld[head] <= 1'b0;
      end
      if (enq) begin
        tail        <= wrap_inc(tail);
        q_vld[tail] <= 1'b1;
      end
      if (enq && !pop)      count <= count + CW'(1);
      else if (pop && !enq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[tail]   <= exe_rd;
      q_data[tail] <= exe_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wen  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      err     <= 1'b0;
    end else begin
      if (push_req && !exe_ready) err <= 1'b1;
      if (mem_valid) begin
        wb_wen  <= 1'b1;
        wb_addr <= mem_rd;
        wb_data <= mem_data;
      end else if (has_q) begin
        wb_wen  <= 1'b1;
        wb_addr <= q_rd[head];
        wb_data <= q_data[head];
      end else if (push_ok) begin
        wb_wen  <= 1'b1;
        wb_addr <= exe_rd;
        wb_data <= exe_data;
      end else begin
        wb_wen  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage: vector table, corner sequences, random vs queue model
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valid, exe_needs_wb, mem_valid;
  logic [3:0]  exe_rd, mem_rd;
  logic [31:0] exe_data, mem_data;
  logic        exe_ready, wb_wen, err;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] pend_mask;

  int checks = 0;
  int errors = 0;

  wb_stage #(.DATA_W(32), .ADDR_W(4), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid(exe_valid), .exe_needs_wb(exe_needs_wb), .exe_rd(exe_rd), .exe_data(exe_data),
    .exe_ready(exe_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_wen(wb_wen),
    .pend_mask(pend_mask), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_wen, m_err;
  logic [3:0]  m_addr;
  logic [31:0] m_data;

  typedef struct {
    logic        ev, nwb;
    logic [3:0]  erd;
    logic [31:0] ed;
    logic        mv;
    logic [3:0]  mrd;
    logic [31:0] md;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] pend;
    logic        rdy, er;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wen = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
  endtask

  function automatic logic [15:0] model_pend();
    logic [15:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  // Drive one cycle of inputs, advance the model by the arbitration rules, sample 1 after the edge.
  task automatic apply(input logic ev, input logic nwb, input logic [3:0] erd, input logic [31:0] ed,
                       input logic mv, input logic [3:0] mrd, input logic [31:0] md);
    logic rdy, push, acc;
    ent_t e;
    exe_valid = ev; exe_needs_wb = nwb; exe_rd = erd; exe_data = ed;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    rdy  = (mq.size() < 2);
    push = ev & nwb;
    acc  = push & rdy;
    if (push && !rdy) m_err = 1'b1;
    e.rd = erd; e.data = ed;
    if (mv) begin
      m_wen = 1'b1; m_addr = mrd; m_data = md;
      if (acc) mq.push_back(e);
    end else if (mq.size() > 0) begin
      ent_t h = mq.pop_front();
      m_wen = 1'b1; m_addr = h.rd; m_data = h.data;
      if (acc) mq.push_back(e);
    end else if (acc) begin
      m_wen = 1'b1; m_addr = erd; m_data = ed;
    end else begin
      m_wen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " wen"}, wb_wen, m_wen);
    if (m_wen) begin
      chk({tag, " addr"}, wb_addr, m_addr);
      chk({tag, " data"}, wb_data, m_data);
    end
    chk({tag, " pend"}, pend_mask, model_pend());
    chk({tag, " ready"}, exe_ready, mq.size() < 2);
    chk({tag, " err"}, err, m_err);
  endtask

  initial begin
    rst_n = 1'b0;
    exe_valid = 0; exe_needs_wb = 0; exe_rd = 0; exe_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    model_reset();
    #12 rst_n = 1'b1;

    chk("reset wen", wb_wen, 0);
    chk("reset addr", wb_addr, 0);
    chk("reset data", wb_data, 0);
    chk("reset err", err, 0);
    chk("reset pend", pend_mask, 0);
    chk("reset ready", exe_ready, 1);

    //            ev nwb erd    ed             mv mrd    md             wen addr  data           pend      rdy er
    tbl[0]  = '{1, 1, 4'd3,  32'h0000_1234, 0, 4'd0,  32'h0,         1, 4'd3,  32'h0000_1234, 16'h0000, 1, 0};
    tbl[1]  = '{0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,         0, 4'd3,  32'h0000_1234, 16'h0000, 1, 0};
    tbl[2]  = '{1, 1, 4'd6,  32'h0000_BBBB, 1, 4'd5,  32'hAAAA_0000, 1, 4'd5,  32'hAAAA_0000, 16'h0040, 1, 0};
    tbl[3]  = '{0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,         1, 4'd6,  32'h0000_BBBB, 16'h0000, 1, 0};
    tbl[4]  = '{0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,         0, 4'd6,  32'h0000_BBBB, 16'h0000, 1, 0};
    tbl[5]  = '{1, 1, 4'd1,  32'h1111_1111, 1, 4'd10, 32'h0000_000A, 1, 4'd10, 32'h0000_000A, 16'h0002, 1, 0};
    tbl[6]  = '{1, 1, 4'd2,  32'h2222_2222, 1, 4'd11, 32'h0000_000B, 1, 4'd11, 32'h0000_000B, 16'h0006, 0, 0};
    tbl[7]  = '{0, 0, 4'd0,  32'h0,         1, 4'd12, 32'h0000_000C, 1, 4'd12, 32'h0000_000C, 16'h0006, 0, 0};
    tbl[8]  = '{0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,         1, 4'd1,  32'h1111_1111, 16'h0004, 1, 0};
    tbl[9]  = '{0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,         1, 4'd2,  32'h2222_2222, 16'h0000, 1, 0};
    tbl[10] = '{0, 0, 4'd0,  32'h0,         0, 4'd0,  32'h0,         0, 4'd2,  32'h2222_2222, 16'h0000, 1, 0};
    tbl[11] = '{1, 0, 4'd7,  32'h0000_0077, 0, 4'd0,  32'h0,         0, 4'd2,  32'h2222_2222, 16'h0000, 1, 0};

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ev, tbl[i].nwb, tbl[i].erd, tbl[i].ed, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      chk($sformatf("vec%0d wen", i), wb_wen, tbl[i].wen);
      chk($sformatf("vec%0d addr", i), wb_addr, tbl[i].addr);
      chk($sformatf("vec%0d data", i), wb_data, tbl[i].data);
      chk($sformatf("vec%0d pend", i), pend_mask, tbl[i].pend);
      chk($sformatf("vec%0d ready", i), exe_ready, tbl[i].rdy);
      chk($sformatf("vec%0d err", i), err, tbl[i].er);
    end

    // Reset mid-cycle with two entries queued behind loads.
    apply(1, 1, 4'd1, 32'h0101_0101, 1, 4'd13, 32'h0000_000D);
    apply(1, 1, 4'd2, 32'h0202_0202, 1, 4'd14, 32'h0000_000E);
    chk("rst pre ready", exe_ready, 0);
    chk("rst pre pend", pend_mask, 16'h0006);
    idle();
    exe_valid = 0; mem_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst async wen", wb_wen, 0);
    chk("rst async addr", wb_addr, 0);
    chk("rst async data", wb_data, 0);
    chk("rst async pend", pend_mask, 0);
    chk("rst async ready", exe_ready, 1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("rst post%0d wen", i), wb_wen, 0);
    end

    // Overflow: push r9 into a full queue; it must be dropped and err must stick.
    apply(1, 1, 4'd4, 32'h0000_0044, 1, 4'd13, 32'h0000_000D);
    apply(1, 1, 4'd5, 32'h0000_0055, 1, 4'd14, 32'h0000_000E);
    chk("ovf full ready", exe_ready, 0);
    apply(1, 1, 4'd9, 32'h0000_0099, 0, 4'd0, 32'h0);
    chk("ovf err", err, 1);
    chk("ovf w0 addr", wb_addr, 4);
    chk("ovf w0 data", wb_data, 32'h44);
    chk("ovf pend", pend_mask, 16'h0020);
    idle();
    chk("ovf w1 wen", wb_wen, 1);
    chk("ovf w1 addr", wb_addr, 5);
    chk("ovf w1 data", wb_data, 32'h55);
    idle();
    chk("ovf drained wen", wb_wen, 0);
    chk("ovf err sticky", err, 1);
    chk("ovf drained pend", pend_mask, 0);

    // Randomized traffic against the queue model, starting from a clean reset.
    #2 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)), $urandom);
      chk_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
